// File: rtl/powerup_manager.sv
// powerup_manager: multi-slot power-up spawner, lifetime/blink tracker and
// pixel renderer for the Pong playfield.
//
// Handshake note: there is no back-pressure anywhere. Every input strobe
// (spawn, eat, frame) is acted on at the clock edge that samples it. Every
// output strobe (spawn_ack, spawn_full, eat_valid, eat_multi, expire) is a
// single-cycle pulse registered at that same edge. spawn_slot and eat_mode
// hold their last reported value between pulses. The per-slot FREE/LIVE
// state is always visible on `active`.
module powerup_manager #(
  parameter int          SLOTS        = 4,
  parameter int          WIDTH        = 20,
  parameter int          HEIGHT       = 20,
  parameter int          X_MAX        = 1004,
  parameter int          Y_MAX        = 748,
  parameter int          LIFETIME     = 600,
  parameter int          BLINK_FRAMES = 120,
  parameter logic [15:0] SEED         = 16'hACE1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame,
  input  logic             spawn,
  input  logic [SLOTS-1:0] eat,
  input  logic [10:0]      hcount,
  input  logic [9:0]       vcount,
  output logic [7:0]       pixel,
  output logic [SLOTS-1:0] active,
  output logic             spawn_ack,
  output logic [2:0]       spawn_slot,
  output logic             spawn_full,
  output logic             eat_valid,
  output logic [1:0]       eat_mode,
  output logic             eat_multi,
  output logic             expire
);

  typedef enum logic {
    FREE = 1'b0,
    LIVE = 1'b1
  } slot_state_t;

  localparam logic [10:0] X_MAX_L = 11'(X_MAX);
  localparam logic [10:0] Y_MAX_L = 11'(Y_MAX);
  localparam logic [9:0]  LIFE_L  = 10'(LIFETIME);
  localparam logic [9:0]  BLINK_L = 10'(BLINK_FRAMES);
  localparam logic [11:0] W12     = 12'(WIDTH);
  localparam logic [11:0] H12     = 12'(HEIGHT);
  localparam logic [15:0] TAPS    = 16'hB400;

  // Registered state
  slot_state_t state_q [SLOTS];
  logic [1:0]  mode_q  [SLOTS];
  logic [10:0] rx_q    [SLOTS];
  logic [9:0]  ry_q    [SLOTS];
  logic [9:0]  life_q  [SLOTS];
  logic [15:0] lfsr_q;
  logic [3:0]  fcnt_q;

  // Next-state values
  slot_state_t state_d [SLOTS];
  logic [1:0]  mode_d  [SLOTS];
  logic [10:0] rx_d    [SLOTS];
  logic [9:0]  ry_d    [SLOTS];
  logic [9:0]  life_d  [SLOTS];
  logic [15:0] lfsr_d;
  logic [3:0]  fcnt_d;
  logic        ack_d, full_d, ev_d, multi_d, expire_d;
  logic [2:0]  slot_d;
  logic [1:0]  em_d;

  // Allocation / eat bookkeeping
  logic             free_found;
  logic [2:0]       free_idx;
  logic [SLOTS-1:0] spawn_sel;
  logic [SLOTS-1:0] eaten;
  logic [3:0]       eat_cnt;
  logic [1:0]       eat_lo_mode;

  // Random placement candidates derived from the current LFSR value
  logic [10:0] rx_cand, ry_sum, rx_new;
  logic [9:0]  ry_new;
  logic [7:0]  pixel_d;

  function automatic logic [7:0] mode_colour(input logic [1:0] m);
    case (m)
      2'b00:   return 8'b000_000_11;  // SLOW
      2'b01:   return 8'b000_101_10;  // BOOST
      2'b10:   return 8'b111_000_11;  // EXTRA
      default: return 8'b111_100_00;  // SHIELD
    endcase
  endfunction

  // Box hit test done at 12 bits so rx+WIDTH never wraps past the screen edge.
  function automatic logic box_covers(input logic [10:0] x, input logic [9:0] y,
                                      input logic [10:0] h, input logic [9:0] v);
    logic [11:0] h12, v12, x12, y12;
    h12 = {1'b0, h};
    v12 = {2'b0, v};
    x12 = {1'b0, x};
    y12 = {2'b0, y};
    return (h12 >= x12) && (h12 < x12 + W12) && (v12 >= y12) && (v12 < y12 + H12);
  endfunction

  // Slot state mirrors straight onto the occupied flags.
  always_comb begin
    active = '0;
    for (int i = 0; i < SLOTS; i++) active[i] = (state_q[i] == LIVE);
  end

  // Placement for a spawn this cycle: clamp so the box stays on screen.
  always_comb begin
    rx_cand = {1'b0, lfsr_q[9:0]};
    ry_sum  = {2'b0, lfsr_q[13:5]} + {6'b0, lfsr_q[4:0]};
    rx_new  = (rx_cand > X_MAX_L) ? X_MAX_L : rx_cand;
    ry_new  = (ry_sum > Y_MAX_L) ? Y_MAX_L[9:0] : ry_sum[9:0];
  end

  // Next-state: allocation, eats, frame-driven lifetime, LFSR and pulses.
  always_comb begin
    lfsr_d      = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? TAPS : 16'h0000);
    fcnt_d      = frame ? fcnt_q + 4'd1 : fcnt_q;
    ack_d       = 1'b0;
    full_d      = 1'b0;
    ev_d        = 1'b0;
    multi_d     = 1'b0;
    expire_d    = 1'b0;
    slot_d      = spawn_slot;
    em_d        = eat_mode;
    free_found  = 1'b0;
    free_idx    = '0;
    spawn_sel   = '0;
    eaten       = '0;
    eat_cnt     = '0;
    eat_lo_mode = '0;
    for (int i = 0; i < SLOTS; i++) begin
      state_d[i] = state_q[i];
      mode_d[i]  = mode_q[i];
      rx_d[i]    = rx_q[i];
      ry_d[i]    = ry_q[i];
      life_d[i]  = life_q[i];
    end

    // Descending scan so the lowest index is the one left standing.
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (state_q[i] == FREE) begin
        free_found = 1'b1;
        free_idx   = 3'(i);
      end
      if (state_q[i] == LIVE && eat[i]) begin
        eaten[i]    = 1'b1;
        eat_lo_mode = mode_q[i];
        eat_cnt     = eat_cnt + 4'd1;
      end
    end

    // Allocation looks at pre-update occupancy, so a slot freed this cycle
    // cannot be handed out until the next one.
    for (int i = 0; i < SLOTS; i++)
      spawn_sel[i] = spawn && free_found && (free_idx == 3'(i));

    for (int i = 0; i < SLOTS; i++) begin
      if (state_q[i] == LIVE) begin
        if (eaten[i]) begin
          // An eat wins over a same-cycle timeout: no expire for this slot.
          state_d[i] = FREE;
        end else if (frame) begin
          if (life_q[i] == 10'd1) begin
            state_d[i] = FREE;
            expire_d   = 1'b1;
          end
          life_d[i] = life_q[i] - 10'd1;
        end
      end else if (spawn_sel[i]) begin
        state_d[i] = LIVE;
        mode_d[i]  = lfsr_q[15:14];
        rx_d[i]    = rx_new;
        ry_d[i]    = ry_new;
        life_d[i]  = LIFE_L;
      end
    end

    if (spawn) begin
      if (free_found) begin
        ack_d  = 1'b1;
        slot_d = free_idx;
      end else begin
        full_d = 1'b1;
      end
    end

    if (eat_cnt != 4'd0) begin
      ev_d    = 1'b1;
      em_d    = eat_lo_mode;
      multi_d = (eat_cnt > 4'd1);
    end
  end

  // State register: synchronous reset clears every slot and every pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q     <= SEED;
      fcnt_q     <= '0;
      spawn_ack  <= 1'b0;
      spawn_slot <= '0;
      spawn_full <= 1'b0;
      eat_valid  <= 1'b0;
      eat_mode   <= '0;
      eat_multi  <= 1'b0;
      expire     <= 1'b0;
      for (int i = 0; i < SLOTS; i++) begin
        state_q[i] <= FREE;
        mode_q[i]  <= '0;
        rx_q[i]    <= '0;
        ry_q[i]    <= '0;
        life_q[i]  <= '0;
      end
    end else begin
      lfsr_q     <= lfsr_d;
      fcnt_q     <= fcnt_d;
      spawn_ack  <= ack_d;
      spawn_slot <= slot_d;
      spawn_full <= full_d;
      eat_valid  <= ev_d;
      eat_mode   <= em_d;
      eat_multi  <= multi_d;
      expire     <= expire_d;
      for (int i = 0; i < SLOTS; i++) begin
        state_q[i] <= state_d[i];
        mode_q[i]  <= mode_d[i];
        rx_q[i]    <= rx_d[i];
        ry_q[i]    <= ry_d[i];
        life_q[i]  <= life_d[i];
      end
    end
  end

  // Pixel mux: lowest-index live, non-blinked-out box covering the pixel wins.
  always_comb begin
    pixel_d = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (state_q[i] == LIVE &&
          box_covers(rx_q[i], ry_q[i], hcount, vcount) &&
          !((life_q[i] <= BLINK_L) && fcnt_q[3]))
        pixel_d = mode_colour(mode_q[i]);
    end
  end

  assign pixel = reset ? 8'd0 : pixel_d;

endmodule

// File: tb/tb_powerup_manager.sv
// Testbench for powerup_manager: directed scenarios, with a scoreboard that
// matches every output pulse against expected events queued by the drivers.
module tb_powerup_manager;

  localparam int SLOTS = 4;
  localparam int EW    = 14;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             reset;
  logic             frame, spawn;
  logic [SLOTS-1:0] eat;
  logic [10:0]      hcount;
  logic [9:0]       vcount;
  logic [7:0]       pixel;
  logic [SLOTS-1:0] active;
  logic             spawn_ack, spawn_full, eat_valid, eat_multi, expire;
  logic [2:0]       spawn_slot;
  logic [1:0]       eat_mode;

  always #5 clk = ~clk;

  powerup_manager #(
    .SLOTS(SLOTS), .LIFETIME(4), .BLINK_FRAMES(2)
  ) dut (
    .clk(clk), .reset(reset), .frame(frame), .spawn(spawn), .eat(eat),
    .hcount(hcount), .vcount(vcount), .pixel(pixel), .active(active),
    .spawn_ack(spawn_ack), .spawn_slot(spawn_slot), .spawn_full(spawn_full),
    .eat_valid(eat_valid), .eat_mode(eat_mode), .eat_multi(eat_multi),
    .expire(expire)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Software LFSR and frame counter, kept in step with the clock.
  logic [15:0] lfsr_m;
  logic [3:0]  fcnt_m;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) lfsr_m <= 16'hACE1;
    else       lfsr_m <= {1'b0, lfsr_m[15:1]} ^ (lfsr_m[0] ? 16'hB400 : 16'h0000);
  end

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int            due_q[$];

  function automatic logic [EW-1:0] mk(input logic a, input logic [2:0] s, input logic f,
                                       input logic ev, input logic [1:0] em, input logic mu,
                                       input logic ex, input logic [3:0] act);
    return {a, s, f, ev, em, mu, ex, act};
  endfunction

  function automatic logic [7:0] colour(input logic [1:0] m);
    case (m)
      2'b00:   return 8'h03;
      2'b01:   return 8'h16;
      2'b10:   return 8'hE3;
      default: return 8'hF0;
    endcase
  endfunction

  // Monitor: any pulse on the output side pops one expected event.
  always @(negedge clk) begin
    logic [EW-1:0] obs, e;
    int            d;
    if (spawn_ack || spawn_full || eat_valid || eat_multi || expire) begin
      obs = {spawn_ack, (spawn_ack ? spawn_slot : 3'd0), spawn_full, eat_valid,
             (eat_valid ? eat_mode : 2'd0), eat_multi, expire, active};
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected cycle=%0d got=%h required=none", cyc, obs);
      end else begin
        e = exp_q.pop_front();
        d = due_q.pop_front();
        if (obs !== e || d != cyc) begin
          fails++;
          $display("FAIL sb_event cycle=%0d got=%h required=%h due_cycle=%0d", cyc, obs, e, d);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s got=%h required=%h", name, got, req);
    end
  endtask

  // ---------------- drivers ----------------
  // Called right after a negedge; returns at the next negedge.
  task automatic drive(input logic s, input logic [3:0] e, input logic f,
                       input logic push, input logic [EW-1:0] ev);
    spawn = s;
    eat   = e;
    frame = f;
    if (push) begin
      exp_q.push_back(ev);
      due_q.push_back(cyc + 1);
    end
    if (f) fcnt_m = fcnt_m + 4'd1;
    @(negedge clk);
    spawn = 1'b0;
    eat   = '0;
    frame = 1'b0;
  endtask

  task automatic do_spawn(input logic [2:0] slot, input logic [3:0] act,
                          output logic [1:0] m, output logic [10:0] x, output logic [9:0] y);
    logic [15:0] l;
    logic [10:0] s;
    l = lfsr_m;
    m = l[15:14];
    x = (l[9:0] > 10'd1004) ? 11'd1004 : {1'b0, l[9:0]};
    s = {2'b0, l[13:5]} + {6'b0, l[4:0]};
    y = (s > 11'd748) ? 10'd748 : s[9:0];
    drive(1'b1, 4'b0000, 1'b0, 1'b1, mk(1'b1, slot, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, act));
  endtask

  task automatic probe(input string name, input logic [10:0] h, input logic [9:0] v,
                       input logic [7:0] req);
    hcount = h;
    vcount = v;
    #1;
    check(name, {24'd0, pixel}, {24'd0, req});
    @(negedge clk);
  endtask

  task automatic wait_mode(input logic [1:0] m);
    int n = 0;
    while (lfsr_m[15:14] != m && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 4000) begin
      tests++;
      fails++;
      $display("FAIL wait_mode timeout got=%h required=%h", lfsr_m[15:14], m);
    end
  endtask

  task automatic wait_rx_clamp();
    int n = 0;
    while (lfsr_m[9:0] < 10'd1005 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 4000) begin
      tests++;
      fails++;
      $display("FAIL wait_rx_clamp timeout got=%h required=>=3ED", lfsr_m[9:0]);
    end
  endtask

  task automatic frames_until(input logic [3:0] target);
    for (int k = 0; k < 16 && fcnt_m != target; k++)
      drive(1'b0, 4'b0000, 1'b1, 1'b0, '0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0]  m0, m1, m2, m3, mx;
    logic [10:0] rx0, rx1, rx2, rx3, rxx;
    logic [9:0]  ry0, ry1, ry2, ry3, ryx;

    reset  = 1'b1;
    spawn  = 1'b0;
    eat    = '0;
    frame  = 1'b0;
    hcount = '0;
    vcount = '0;
    fcnt_m = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    check("rst_active", {28'd0, active}, 32'd0);
    check("rst_pulses", {27'd0, spawn_ack, spawn_full, eat_valid, eat_multi, expire}, 32'd0);
    check("rst_spawn_slot", {29'd0, spawn_slot}, 32'd0);
    check("rst_eat_mode", {30'd0, eat_mode}, 32'd0);

    // First spawn lands in slot 0 at the LFSR-derived place and colour
    do_spawn(3'd0, 4'b0001, m0, rx0, ry0);
    check("t1_active", {28'd0, active}, 32'h1);
    probe("t1_origin", rx0, ry0, colour(m0));
    probe("t1_far_corner", rx0 + 11'd19, ry0 + 10'd19, colour(m0));
    probe("t1_right_out", rx0 + 11'd20, ry0, 8'h00);
    probe("t1_below_out", rx0, ry0 + 10'd20, 8'h00);

    // Fill the remaining slots, then one more spawn overflows
    do_spawn(3'd1, 4'b0011, m1, rx1, ry1);
    do_spawn(3'd2, 4'b0111, m2, rx2, ry2);
    do_spawn(3'd3, 4'b1111, m3, rx3, ry3);
    drive(1'b1, 4'b0000, 1'b0, 1'b1, mk(1'b0, 3'd0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 4'b1111));
    check("t2_active_full", {28'd0, active}, 32'hF);
    probe("t2_slot0_priority", rx0, ry0, colour(m0));

    // Eat everything at once: lowest reported, multi flagged
    drive(1'b0, 4'b1111, 1'b0, 1'b1, mk(1'b0, 3'd0, 1'b0, 1'b1, m0, 1'b1, 1'b0, 4'b0000));
    check("t3_active_clear", {28'd0, active}, 32'h0);
    drive(1'b0, 4'b0010, 1'b0, 1'b0, '0);
    check("t3_eat_free_quiet", {27'd0, spawn_ack, spawn_full, eat_valid, eat_multi, expire}, 32'd0);

    // Slots 0 (BOOST), 1 (any), 2 (SHIELD); eat 0 and 2 together
    wait_mode(2'b01);
    do_spawn(3'd0, 4'b0001, m0, rx0, ry0);
    do_spawn(3'd1, 4'b0011, m1, rx1, ry1);
    wait_mode(2'b11);
    do_spawn(3'd2, 4'b0111, m2, rx2, ry2);
    drive(1'b0, 4'b0101, 1'b0, 1'b1, mk(1'b0, 3'd0, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 4'b0010));
    check("t4_active_after_pair", {28'd0, active}, 32'h2);
    drive(1'b0, 4'b0010, 1'b0, 1'b1, mk(1'b0, 3'd0, 1'b0, 1'b1, m1, 1'b0, 1'b0, 4'b0000));
    probe("t4_slot2_gone", rx2, ry2, 8'h00);

    // Right-edge clamp and no wrap past column 1023
    wait_rx_clamp();
    do_spawn(3'd0, 4'b0001, mx, rxx, ryx);
    probe("t5_left_edge", 11'd1004, ryx, colour(mx));
    probe("t5_last_pixel", 11'd1023, ryx + 10'd19, colour(mx));
    probe("t5_before_box", 11'd1003, ryx, 8'h00);
    probe("t5_no_wrap", 11'd1024, ryx, 8'h00);
    drive(1'b0, 4'b0001, 1'b0, 1'b1, mk(1'b0, 3'd0, 1'b0, 1'b1, mx, 1'b0, 1'b0, 4'b0000));

    // Lifetime 4, blink from life 2; frame counter steered to 6 first
    frames_until(4'd6);
    do_spawn(3'd0, 4'b0001, mx, rxx, ryx);
    probe("t6_fresh", rxx, ryx, colour(mx));
    drive(1'b0, 4'b0000, 1'b1, 1'b0, '0);
    probe("t6_life3_visible", rxx, ryx, colour(mx));
    drive(1'b0, 4'b0000, 1'b1, 1'b0, '0);
    probe("t6_life2_hidden", rxx, ryx, 8'h00);
    check("t6_still_live", {28'd0, active}, 32'h1);
    drive(1'b0, 4'b0000, 1'b1, 1'b0, '0);
    drive(1'b0, 4'b0000, 1'b1, 1'b1, mk(1'b0, 3'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 4'b0000));
    check("t6_expired", {28'd0, active}, 32'h0);

    // Eat beats expiry, full spawn dropped, slot reused next cycle
    frames_until(4'd13);
    do_spawn(3'd0, 4'b0001, m0, rx0, ry0);
    repeat (3) drive(1'b0, 4'b0000, 1'b1, 1'b0, '0);
    probe("t7_blink_visible", rx0, ry0, colour(m0));
    do_spawn(3'd1, 4'b0011, m1, rx1, ry1);
    do_spawn(3'd2, 4'b0111, m2, rx2, ry2);
    do_spawn(3'd3, 4'b1111, m3, rx3, ry3);
    drive(1'b1, 4'b0001, 1'b1, 1'b1, mk(1'b0, 3'd0, 1'b1, 1'b1, m0, 1'b0, 1'b0, 4'b1110));
    do_spawn(3'd0, 4'b1111, m0, rx0, ry0);

    // Reset mid-operation with strobes asserted
    reset  = 1'b1;
    spawn  = 1'b1;
    eat    = 4'b1111;
    frame  = 1'b1;
    hcount = rx0;
    vcount = ry0;
    #1;
    check("t8_pixel_in_reset", {24'd0, pixel}, 32'd0);
    @(negedge clk);
    reset  = 1'b0;
    spawn  = 1'b0;
    eat    = '0;
    frame  = 1'b0;
    fcnt_m = '0;
    check("t8_active", {28'd0, active}, 32'd0);
    check("t8_pulses", {27'd0, spawn_ack, spawn_full, eat_valid, eat_multi, expire}, 32'd0);
    do_spawn(3'd0, 4'b0001, m0, rx0, ry0);
    probe("t8_reseeded_spawn", rx0, ry0, colour(m0));

    repeat (3) @(negedge clk);
    check("sb_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
